// File: rtl/pipestage_skid_if.sv
`default_nettype none
// ============================================================================
// Module  : pipestage_skid_if
// Purpose : Upstream/downstream handshake bundle for pipestage_skid.
//           stall_cnt is present only when PIPESTAGE_PERF_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
interface pipestage_skid_if #(
    parameter int WIDTH = 71
) ();
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occ;
`ifdef PIPESTAGE_PERF_EN
    logic [15:0]      stall_cnt;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occ, stall_cnt
    );
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occ, stall_cnt
    );
`else
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occ
    );
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occ
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pipestage_skid.sv
`default_nettype none
// ============================================================================
// Module  : pipestage_skid
// Purpose : Two-entry skid pipeline stage (main + skid register) with fully
//           registered in_ready, flush and optional stall counter
//           (macro PIPESTAGE_PERF_EN).
// Revision: 1.0  initial release
// ============================================================================
module pipestage_skid #(
    parameter int WIDTH = 71,
    parameter int CTRL  = 2
) (
    input  wire logic         clk,
    input  wire logic         clr,
    pipestage_skid_if.slave   bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Low CTRL bits of the payload are control bits that must read 0 when idle.
    localparam logic [WIDTH-1:0] c_ctrl_mask =
        (CTRL == 0) ? '0 : ({WIDTH{1'b1}} >> (WIDTH - CTRL));

    state_t           r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [1:0]       r_occ;

    state_t           w_next_state;
    logic             w_accept;
    logic             w_transfer;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_main_from_skid;
    logic             w_clear_ctrl;

    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_transfer = r_out_valid & bus.out_ready;

    always_comb begin
        w_next_state     = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        w_clear_ctrl     = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_load_main  = 1'b1;
                    w_next_state = ONE;
                end
            end
            ONE: begin
                if (w_accept && w_transfer) begin
                    w_load_main  = 1'b1;
                end else if (w_accept) begin
                    w_load_skid  = 1'b1;
                    w_next_state = TWO;
                end else if (w_transfer) begin
                    w_clear_ctrl = 1'b1;
                    w_next_state = EMPTY;
                end
            end
            TWO: begin
                if (w_transfer) begin
                    w_main_from_skid = 1'b1;
                    w_next_state     = ONE;
                end
            end
            default: begin
                w_clear_ctrl = 1'b1;
                w_next_state = EMPTY;
            end
        endcase
    end

    // Handshake outputs are decoded from the next state into flops so that
    // in_ready never has a combinational path from out_ready.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
        end else if (bus.flush) begin
            r_state     <= EMPTY;
            r_main      <= r_main & ~c_ctrl_mask;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state != TWO);
            r_out_valid <= (w_next_state != EMPTY);
            r_occ       <= w_next_state;
            if (w_load_main) begin
                r_main <= bus.in_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end else if (w_clear_ctrl) begin
                r_main <= r_main & ~c_ctrl_mask;
            end
            if (w_load_skid) begin
                r_skid <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_main;
    assign bus.occ       = r_occ;

`ifdef PIPESTAGE_PERF_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles where a held beat is back-pressured.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_stall_cnt <= 16'd0;
        end else if (r_out_valid && !bus.out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
